// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage and its iterative MUL/DIV datapath.
package exec_pkg;

    localparam int WIDTH   = 8;
    localparam int RADDR_W = 3;
    localparam int ITER    = WIDTH;

    localparam logic [RADDR_W-1:0] OVER_REG = 3'd7;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_MUL = 3'd6,
        OP_DIV = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        WB   = 2'd3
    } state_t;

endpackage

// File: rtl/mul_div_seq.sv
// Iterative unsigned multiplier / restoring divider: one product or quotient bit per cycle.
module mul_div_seq
    import exec_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   operand;
    logic               div_mode;
    logic [3:0]         count;
    logic               busy;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;

    // acc holds {partial product high, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        shifted  = acc[2*WIDTH-1:WIDTH-1];
        diff     = shifted - {1'b0, operand};
        acc_next = acc;
        if (div_mode) begin
            if (shifted >= {1'b0, operand}) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                acc_next = {sum, acc[WIDTH-1:1]};
            end else begin
                acc_next = {1'b0, acc[2*WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            operand  <= '0;
            div_mode <= 1'b0;
            count    <= '0;
            busy     <= 1'b0;
        end else if (start) begin
            acc      <= {{WIDTH{1'b0}}, (is_div ? a : b)};
            operand  <= is_div ? b : a;
            div_mode <= is_div;
            count    <= '0;
            busy     <= 1'b1;
        end else if (busy) begin
            acc   <= acc_next;
            count <= count + 4'd1;
            if (count == 4'(ITER - 1)) begin
                busy <= 1'b0;
            end
        end
    end

    // Results are taken from the final step's next value so the caller can latch them on the same edge
    assign done = busy && (count == 4'(ITER - 1));
    assign lo   = acc_next[WIDTH-1:0];
    assign hi   = acc_next[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/exec_unit.sv
// Execute stage feeding the register file write port: single-cycle ALU plus iterative MUL/DIV.
module exec_unit
    import exec_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [RADDR_W-1:0] dest_i,
    output logic               writeFlag_o,
    output logic               overFlag_o,
    output logic [RADDR_W-1:0] destReg_o,
    output logic [WIDTH-1:0]   data_o,
    output logic [WIDTH-1:0]   over_o
);

    state_t             state;
    state_t             next_state;
    opcode_t            op;
    logic               accept;
    logic               is_iter;
    logic [RADDR_W-1:0] dest_r;

    logic               seq_done;
    logic [WIDTH-1:0]   seq_lo;
    logic [WIDTH-1:0]   seq_hi;

    logic [WIDTH:0]     sum9;
    logic [WIDTH:0]     diff9;
    logic [2*WIDTH-1:0] shl16;
    logic [WIDTH-1:0]   alu_data;
    logic [WIDTH-1:0]   alu_over;
    logic               alu_of;

    logic               nx_write;
    logic               nx_of;
    logic [RADDR_W-1:0] nx_dest;
    logic [WIDTH-1:0]   nx_data;
    logic [WIDTH-1:0]   nx_over;

    assign op      = opcode_t'(op_i);
    assign ready_o = (state == IDLE);
    assign accept  = valid_i && ready_o;
    // Division by zero never enters the iterative path
    assign is_iter = (op == OP_MUL) || ((op == OP_DIV) && (b_i != '0));

    mul_div_seq u_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && is_iter),
        .is_div (op == OP_DIV),
        .a      (a_i),
        .b      (b_i),
        .done   (seq_done),
        .lo     (seq_lo),
        .hi     (seq_hi)
    );

    always_comb begin
        sum9     = {1'b0, a_i} + {1'b0, b_i};
        diff9    = {1'b0, a_i} - {1'b0, b_i};
        shl16    = {{WIDTH{1'b0}}, a_i} << b_i[2:0];
        alu_data = '0;
        alu_over = '0;
        alu_of   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_data = sum9[WIDTH-1:0];
                alu_over = {{(WIDTH-1){1'b0}}, sum9[WIDTH]};
                alu_of   = 1'b1;
            end
            OP_SUB: begin
                alu_data = diff9[WIDTH-1:0];
                alu_over = {{(WIDTH-1){1'b0}}, diff9[WIDTH]};
                alu_of   = 1'b1;
            end
            OP_AND: alu_data = a_i & b_i;
            OP_OR:  alu_data = a_i | b_i;
            OP_XOR: alu_data = a_i ^ b_i;
            OP_SHL: begin
                alu_data = shl16[WIDTH-1:0];
                alu_over = shl16[2*WIDTH-1:WIDTH];
                alu_of   = 1'b1;
            end
            OP_DIV: begin
                alu_data = '1;
                alu_over = a_i;
                alu_of   = 1'b1;
            end
            default: begin
                alu_data = '0;
                alu_over = '0;
                alu_of   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Output registers load only on entry to WB, so they are zero in every other state
    always_comb begin
        next_state = state;
        nx_write   = 1'b0;
        nx_of      = 1'b0;
        nx_dest    = '0;
        nx_data    = '0;
        nx_over    = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_iter) begin
                        next_state = (op == OP_DIV) ? DIV : MUL;
                    end else begin
                        next_state = WB;
                        nx_write   = 1'b1;
                        nx_of      = alu_of;
                        nx_dest    = dest_i;
                        nx_data    = alu_data;
                        nx_over    = alu_over;
                    end
                end
            end
            MUL, DIV: begin
                if (seq_done) begin
                    next_state = WB;
                    nx_write   = 1'b1;
                    nx_of      = 1'b1;
                    nx_dest    = dest_r;
                    nx_data    = seq_lo;
                    nx_over    = seq_hi;
                end
            end
            WB: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dest_r      <= '0;
            writeFlag_o <= 1'b0;
            overFlag_o  <= 1'b0;
            destReg_o   <= '0;
            data_o      <= '0;
            over_o      <= '0;
        end else begin
            if (accept) begin
                dest_r <= dest_i;
            end
            writeFlag_o <= nx_write;
            overFlag_o  <= nx_of;
            destReg_o   <= nx_dest;
            data_o      <= nx_data;
            over_o      <= nx_over;
        end
    end

endmodule
